q_update: RTL and testbench

Q_UPDATE -- requirements
Module: q_update

---
 rtl/q_learning_pkg.sv | 17 +
 rtl/q_update_fifo.sv | 54 +++++
 rtl/q_update.sv | 136 +++++++++++++
 tb/tb_q_update.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_learning_pkg.sv
// Shared Q-learning definitions: default widths/constants and the buffered
// sample record {addr, q_sa, reward}.
package q_learning_pkg;

  localparam int          DATA_WIDTH_DEF  = 32;
  localparam int          FRAC_BITS_DEF   = 16;
  localparam int          ADDR_WIDTH_DEF  = 8;
  localparam int unsigned GAMMA_DEF       = 58982;  // 0.9 in Q16.16
  localparam int          ALPHA_SHIFT_DEF = 3;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] q_sa;
    logic [DATA_WIDTH_DEF-1:0] reward;
  } sample_t;

endpackage

// File: rtl/q_update_fifo.sv
// Synchronous FIFO with full/empty flags; the head word is readable
// combinationally so it can pair with the max value in the pop cycle.
module q_update_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/q_update.sv
// Q-learning TD update: buffers samples, pairs them with max Q(s',.) and runs
// a 3-stage pipeline to the Q-table write-back. Define Q_UPDATE_SAT_EN to clamp.
module q_update
  import q_learning_pkg::*;
#(
  parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int          FRAC_BITS   = FRAC_BITS_DEF,
  parameter int          ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned GAMMA       = GAMMA_DEF,
  parameter int          ALPHA_SHIFT = ALPHA_SHIFT_DEF,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_q_sa,
  input  logic [DATA_WIDTH-1:0] i_reward,
  output logic                  o_ready,
  input  logic                  i_max_valid,
  input  logic [DATA_WIDTH-1:0] i_max_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_err
);

  localparam int TW = DATA_WIDTH + 2;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] GAMMA_W = PW'(GAMMA);

  logic          fifo_full, fifo_empty, push, pop;
  logic [SW-1:0] head;

  assign o_ready = !fifo_full;
  assign push    = i_valid && o_ready;
  assign pop     = i_max_valid && !fifo_empty;

  q_update_fifo #(.WIDTH(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({i_addr, i_q_sa, i_reward}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage 1: discounted max, carried with the paired sample
  logic                  s1_valid_reg;
  logic [ADDR_WIDTH-1:0] s1_addr_reg;
  logic [DATA_WIDTH-1:0] s1_q_sa_reg, s1_reward_reg;
  logic signed [PW-1:0]  s1_prod_reg, max_ext, prod_c;

  assign max_ext = {{DATA_WIDTH{i_max_data[DATA_WIDTH-1]}}, i_max_data};
  assign prod_c  = max_ext * GAMMA_W;

  // Stage 2: TD error, two guard bits so the sum never overflows
  logic                  s2_valid_reg;
  logic [ADDR_WIDTH-1:0] s2_addr_reg;
  logic [DATA_WIDTH-1:0] s2_q_sa_reg;
  logic signed [TW-1:0]  s2_td_reg;
  logic signed [PW-1:0]  prod_shift;
  logic [TW-1:0]         td_c;
  logic                  unused_prod_hi;

  assign prod_shift     = s1_prod_reg >>> FRAC_BITS;
  assign unused_prod_hi = ^prod_shift[PW-1:TW];
  assign td_c = {{2{s1_reward_reg[DATA_WIDTH-1]}}, s1_reward_reg} + prod_shift[TW-1:0]
              - {{2{s1_q_sa_reg[DATA_WIDTH-1]}}, s1_q_sa_reg};

  // Stage 3: scaled update and narrowing back to DATA_WIDTH
  logic signed [TW-1:0]  td_shift;
  logic [TW-1:0]         q_wide;
  logic [DATA_WIDTH-1:0] q_narrow;

  assign td_shift = s2_td_reg >>> ALPHA_SHIFT;
  assign q_wide   = {{2{s2_q_sa_reg[DATA_WIDTH-1]}}, s2_q_sa_reg} + td_shift;

`ifdef Q_UPDATE_SAT_EN
  logic [2:0] q_top;
  assign q_top = q_wide[TW-1:DATA_WIDTH-1];
  always_comb begin
    q_narrow = q_wide[DATA_WIDTH-1:0];
    if (!((&q_top) || !(|q_top)))
      q_narrow = q_wide[TW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  logic unused_q_hi;
  assign unused_q_hi = ^q_wide[TW-1:DATA_WIDTH];
  assign q_narrow    = q_wide[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_addr_reg   <= '0;
      s1_q_sa_reg   <= '0;
      s1_reward_reg <= '0;
      s1_prod_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      s2_addr_reg   <= '0;
      s2_q_sa_reg   <= '0;
      s2_td_reg     <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_err         <= 1'b0;
    end else begin
      s1_valid_reg <= pop;
      if (pop) begin
        s1_addr_reg   <= head[SW-1 -: ADDR_WIDTH];
        s1_q_sa_reg   <= head[2*DATA_WIDTH-1 -: DATA_WIDTH];
        s1_reward_reg <= head[DATA_WIDTH-1:0];
        s1_prod_reg   <= prod_c;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_addr_reg <= s1_addr_reg;
        s2_q_sa_reg <= s1_q_sa_reg;
        s2_td_reg   <= td_c;
      end
      o_wr_en <= s2_valid_reg;
      if (s2_valid_reg) begin
        o_wr_addr <= s2_addr_reg;
        o_wr_data <= q_narrow;
      end
      // Sticky: overflow drop or a max value with nothing to pair it with
      if ((i_valid && !o_ready) || (i_max_valid && fifo_empty)) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_update.sv
// Self-checking bench for q_update: vector table plus write-back scoreboard,
// with hand sequences for ordering, overflow, underflow and reset.
module tb_q_update;
  import q_learning_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

`ifdef Q_UPDATE_SAT_EN
  localparam logic [DW-1:0] EXP_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] EXP_NEG_OVF = 32'h8000_0000;
`else
  localparam logic [DW-1:0] EXP_POS_OVF = 32'h8E65_4333;
  localparam logic [DW-1:0] EXP_NEG_OVF = 32'h7199_A000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_q_sa = '0;
  logic [DW-1:0] i_reward = '0;
  logic          o_ready;
  logic          i_max_valid = 1'b0;
  logic [DW-1:0] i_max_data = '0;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_err;

  always #5 clk = ~clk;

  q_update dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_q_sa      (i_q_sa),
    .i_reward    (i_reward),
    .o_ready     (o_ready),
    .i_max_valid (i_max_valid),
    .i_max_data  (i_max_data),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_err       (o_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    string         name;
    sample_t       s;
    logic [DW-1:0] max;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-back monitor: every pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", o_wr_addr, o_wr_data);
      end else begin
        mon_e = sb.pop_front();
        $display("write cyc=%0d addr=0x%0h data=0x%0h", cycle_cnt, o_wr_addr, o_wr_data);
        check("wr_addr", 64'(o_wr_addr), 64'(mon_e.addr));
        check("wr_data", 64'(o_wr_data), 64'(mon_e.data));
        check("wr_latency", 64'(cycle_cnt), 64'(mon_e.cyc));
      end
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] q,
                       input logic [DW-1:0] r, input logic mv, input logic [DW-1:0] md,
                       input logic exp_wr, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    @(posedge clk);
    #1;
    i_valid = v; i_addr = a; i_q_sa = q; i_reward = r;
    i_max_valid = mv; i_max_data = md;
    if (exp_wr) begin
      exp_t e;
      e.addr = ea; e.data = ed; e.cyc = cycle_cnt + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, '0, '0, 0, '0, 0, '0, '0);
  endtask

  task automatic push_s(input logic [AW-1:0] a, input logic [DW-1:0] q, input logic [DW-1:0] r);
    drive(1, a, q, r, 0, '0, 0, '0, '0);
  endtask

  task automatic pop_m(input logic [DW-1:0] md, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    drive(0, '0, '0, '0, 1, md, 1, ea, ed);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_valid = 0; i_max_valid = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    idle(2);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  function automatic vec_t mk(input string n, input logic [AW-1:0] a, input logic [DW-1:0] q,
                              input logic [DW-1:0] r, input logic [DW-1:0] m, input logic [DW-1:0] e);
    vec_t v;
    v.name = n; v.s.addr = a; v.s.q_sa = q; v.s.reward = r; v.max = m; v.exp = e;
    return v;
  endfunction

  initial begin
    vecs[0] = mk("basic",    8'h12, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0001_3999);
    vecs[1] = mk("zero",     8'h01, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    vecs[2] = mk("decay",    8'h02, 32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_C000);
    vecs[3] = mk("negative", 8'h03, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_2333);
    vecs[4] = mk("floor",    8'h04, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
    vecs[5] = mk("pos_ovf",  8'hFE, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, EXP_POS_OVF);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(o_wr_en), 64'd0);
    check("rst_wr_addr", 64'(o_wr_addr), 64'd0);
    check("rst_wr_data", 64'(o_wr_data), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table: one sample, one max, one write each
    for (int i = 0; i < 6; i++) begin
      push_s(vecs[i].s.addr, vecs[i].s.q_sa, vecs[i].s.reward);
      pop_m(vecs[i].max, vecs[i].s.addr, vecs[i].exp);
      idle(4);
    end
    push_s(8'hEE, 32'h8000_0000, 32'h8000_0000);
    pop_m(32'h8000_0000, 8'hEE, EXP_NEG_OVF);
    idle(1);
    drain("table_drain");
    check("table_err", 64'(o_err), 64'd0);

    // Ordering: fill, then back-to-back pops give back-to-back writes
    for (int k = 0; k < 4; k++) push_s(AW'(8'hA0 + k), '0, DW'((k + 1) << 16));
    idle(1);
    check("full_ready", 64'(o_ready), 64'd0);
    for (int k = 0; k < 4; k++) pop_m('0, AW'(8'hA0 + k), DW'((k + 1) << 13));
    idle(1);
    check("empty_ready", 64'(o_ready), 64'd1);
    drain("order_drain");
    check("order_err", 64'(o_err), 64'd0);

    // Overflow: fifth push dropped, then simultaneous push/pop keeps occupancy
    for (int k = 0; k < 4; k++) push_s(AW'(8'hB0 + k), '0, DW'((k + 1) << 16));
    push_s(8'h55, '0, 32'h0009_0000);
    idle(1);
    check("ovf_err", 64'(o_err), 64'd1);
    check("ovf_ready", 64'(o_ready), 64'd0);
    pop_m('0, 8'hB0, 32'h0000_2000);
    drive(1, 8'hB4, '0, 32'h0005_0000, 1, '0, 1, 8'hB1, 32'h0000_4000);
    idle(1);
    check("pushpop_ready", 64'(o_ready), 64'd1);
    pop_m('0, 8'hB2, 32'h0000_6000);
    pop_m('0, 8'hB3, 32'h0000_8000);
    pop_m('0, 8'hB4, 32'h0000_A000);
    idle(1);
    check("ovf_ready_after", 64'(o_ready), 64'd1);
    drain("ovf_drain");
    check("ovf_err_sticky", 64'(o_err), 64'd1);

    // Underflow: max with empty FIFO, no write
    apply_reset();
    check("clr_err", 64'(o_err), 64'd0);
    drive(0, '0, '0, '0, 1, 32'h0002_0000, 0, '0, '0);
    idle(6);
    check("udf_err", 64'(o_err), 64'd1);

    // A push into an empty FIFO cannot be popped in the same cycle
    apply_reset();
    drive(1, 8'h77, '0, 32'h0001_0000, 1, '0, 0, '0, '0);
    idle(1);
    check("same_cyc_err", 64'(o_err), 64'd1);
    pop_m('0, 8'h77, 32'h0000_2000);
    idle(1);
    drain("same_cyc_drain");

    // Reset with two samples buffered and one in flight
    apply_reset();
    for (int k = 0; k < 3; k++) push_s(AW'(8'hC0 + k), '0, DW'((k + 1) << 16));
    pop_m('0, 8'hC0, 32'h0000_2000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_valid = 0; i_max_valid = 0;
    sb.delete();
    #2;
    check("mid_rst_wr_en", 64'(o_wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(o_wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(o_wr_data), 64'd0);
    check("mid_rst_err", 64'(o_err), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    check("post_rst_ready", 64'(o_ready), 64'd1);
    // Buffered samples must be gone: a lone max underflows
    drive(0, '0, '0, '0, 1, '0, 0, '0, '0);
    idle(6);
    check("post_rst_empty_err", 64'(o_err), 64'd1);
    push_s(8'h12, 32'h0001_0000, 32'h0001_0000);
    pop_m(32'h0002_0000, 8'h12, 32'h0001_3999);
    idle(1);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
